bridge_demux3: RTL

System bridge that takes one CPU-side memory request and routes it to exactly one of three slaves: data memory, Timer0 or Timer1. It sits between the MEM stage and the peripherals in the P7 CPU. It decodes the address, issues the request with a one-hot slave select, waits for the slave acknowledge under a timeout, and returns a registered one-cycle response carrying either read data or an error flag used to raise AdEL/AdES.

---
 rtl/bridge_pkg.sv | 38 +++
 rtl/bridge_addr_decode.sv | 51 +++++
 rtl/bridge_demux3.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge.
// Contents: FSM state encoding, one-hot slave selects, default address map,
// the registered request record and a range-compare helper.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_DM   = 3'b001;
  localparam logic [2:0] SEL_T0   = 3'b010;
  localparam logic [2:0] SEL_T1   = 3'b100;

  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT = 32'h0000_2FFF;
  localparam logic [31:0] T0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] T0_LIMIT = 32'h0000_7F0B;
  localparam logic [31:0] T1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] T1_LIMIT = 32'h0000_7F1B;

  // Request as held while the slave is being driven; addr is already the offset.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [2:0]  sel;
  } req_t;

  function automatic logic in_range(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decoder for the bridge.
// Ports: addr/we/byteen in; sel (one-hot, zero on error), offset (addr - base),
// err (unmapped, misaligned timer access, or partial timer write).
module bridge_addr_decode
  import bridge_pkg::*;
#(
  parameter logic [31:0] BASE0  = DM_BASE,
  parameter logic [31:0] LIMIT0 = DM_LIMIT,
  parameter logic [31:0] BASE1  = T0_BASE,
  parameter logic [31:0] LIMIT1 = T0_LIMIT,
  parameter logic [31:0] BASE2  = T1_BASE,
  parameter logic [31:0] LIMIT2 = T1_LIMIT
) (
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  output logic [2:0]  sel,
  output logic [31:0] offset,
  output logic        err
);

  logic timer_ok;

  // Timers only take aligned word accesses, and writes must be full-word.
  assign timer_ok = (addr[1:0] == 2'b00) && (!we || byteen == 4'b1111);

  // Priority chain: lowest index wins if ranges were ever configured to overlap.
  always_comb begin
    sel    = SEL_NONE;
    offset = '0;
    err    = 1'b1;
    if (in_range(addr, BASE0, LIMIT0)) begin
      sel    = SEL_DM;
      offset = addr - BASE0;
      err    = 1'b0;
    end else if (in_range(addr, BASE1, LIMIT1)) begin
      if (timer_ok) begin
        sel    = SEL_T0;
        offset = addr - BASE1;
        err    = 1'b0;
      end
    end else if (in_range(addr, BASE2, LIMIT2)) begin
      if (timer_ok) begin
        sel    = SEL_T1;
        offset = addr - BASE2;
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bridge_demux3.sv
// Bridge from the MEM-stage master to DM / Timer0 / Timer1.
// Master side: m_req/m_we/m_addr/m_wdata/m_byteen in, m_ready (comb),
//   m_rvalid/m_rdata/m_err (registered one-cycle response).
// Slave side: s_sel/s_we/s_addr/s_wdata/s_byteen out (nonzero only in ISSUE,
//   driven from registers), s_ack and s_rdata0..2 in.
module bridge_demux3
  import bridge_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] BASE0   = DM_BASE,
  parameter logic [31:0] LIMIT0  = DM_LIMIT,
  parameter logic [31:0] BASE1   = T0_BASE,
  parameter logic [31:0] LIMIT1  = T0_LIMIT,
  parameter logic [31:0] BASE2   = T1_BASE,
  parameter logic [31:0] LIMIT2  = T1_LIMIT,
  parameter int          TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_req,
  input  logic             m_we,
  input  logic [31:0]      m_addr,
  input  logic [WIDTH-1:0] m_wdata,
  input  logic [3:0]       m_byteen,
  output logic             m_ready,
  output logic             m_rvalid,
  output logic [WIDTH-1:0] m_rdata,
  output logic             m_err,
  output logic [2:0]       s_sel,
  output logic             s_we,
  output logic [31:0]      s_addr,
  output logic [WIDTH-1:0] s_wdata,
  output logic [3:0]       s_byteen,
  input  logic [2:0]       s_ack,
  input  logic [WIDTH-1:0] s_rdata0,
  input  logic [WIDTH-1:0] s_rdata1,
  input  logic [WIDTH-1:0] s_rdata2
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  req_t             req;
  logic [WIDTH-1:0] wdata_q;
  logic [7:0]       cnt;

  logic [2:0]       dec_sel;
  logic [31:0]      dec_off;
  logic             dec_err;
  logic             accept, ack_hit, timed_out;
  logic [WIDTH-1:0] rdata_mux;

  bridge_addr_decode #(
    .BASE0(BASE0), .LIMIT0(LIMIT0),
    .BASE1(BASE1), .LIMIT1(LIMIT1),
    .BASE2(BASE2), .LIMIT2(LIMIT2)
  ) u_dec (
    .addr   (m_addr),
    .we     (m_we),
    .byteen (m_byteen),
    .sel    (dec_sel),
    .offset (dec_off),
    .err    (dec_err)
  );

  assign m_ready   = (state == IDLE);
  assign accept    = m_ready && m_req;
  // Acks from slaves other than the registered select are masked off here.
  assign ack_hit   = (state == ISSUE) && |(s_ack & req.sel);
  assign timed_out = (state == ISSUE) && !ack_hit && (cnt == TO_LAST);

  always_comb begin
    rdata_mux = '0;
    unique case (1'b1)
      req.sel[0]: rdata_mux = s_rdata0;
      req.sel[1]: rdata_mux = s_rdata1;
      req.sel[2]: rdata_mux = s_rdata2;
      default:    rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = dec_err ? RESP : ISSUE;
      ISSUE:   if (ack_hit || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, watchdog and the registered response. The response
  // registers are loaded on the edge that enters RESP, so they are valid
  // exactly for the RESP cycle and cleared on the edge that leaves it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req      <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_err    <= 1'b0;
    end else begin
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_err    <= 1'b0;
      cnt      <= (state == ISSUE) ? cnt + 8'd1 : 8'd0;
      if (accept) begin
        req     <= '{we: m_we, addr: dec_off, byteen: m_byteen, sel: dec_sel};
        wdata_q <= m_wdata;
        if (dec_err) begin
          m_rvalid <= 1'b1;
          m_err    <= 1'b1;
        end
      end
      if (ack_hit) begin
        m_rvalid <= 1'b1;
        m_rdata  <= req.we ? '0 : rdata_mux;
      end else if (timed_out) begin
        m_rvalid <= 1'b1;
        m_err    <= 1'b1;
      end
    end
  end

  always_comb begin
    s_sel    = SEL_NONE;
    s_we     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_byteen = '0;
    if (state == ISSUE) begin
      s_sel    = req.sel;
      s_we     = req.we;
      s_addr   = req.addr;
      s_wdata  = wdata_q;
      s_byteen = req.byteen;
    end
  end

endmodule
